op_in_arb: RTL and testbench

//  Round-robin arbiter sharing the single logic-op input port (data1/data2/data_en) among NUM_REQ requesters.

---
 rtl/op_in_arb.sv | 143 ++++++++++++++
 tb/tb_op_in_arb.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/op_in_arb.sv
// rtl/op_in_arb.sv - round-robin arbiter feeding the logic-op input port (data1/data2/data_en)
// Optional grant counters are built when OP_IN_ARB_STAT_EN is defined.
module op_in_arb #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 4,
    parameter int GAP     = 0,
    parameter int CNT_W   = 16,
    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*DW-1:0]    req_data1_i,
    input  logic [NUM_REQ*DW-1:0]    req_data2_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     hold_i,
`ifdef OP_IN_ARB_STAT_EN
    input  logic                     stat_clr_i,
    output logic [NUM_REQ*CNT_W-1:0] stat_cnt_o,
`endif
    output logic [DW-1:0]            data1_o,
    output logic [DW-1:0]            data2_o,
    output logic                     data_en_o,
    output logic [IW-1:0]            grant_id_o
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_INIT = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic {S_ARB, S_GAP} state_t;

    state_t         state_q;
    logic [GW-1:0]  gap_cnt_q;
    logic [IW-1:0]  rr_ptr_q;
    logic [DW-1:0]  data1_q;
    logic [DW-1:0]  data2_q;
    logic           data_en_q;
    logic [IW-1:0]  grant_id_q;

    logic           win_found;
    logic [IW-1:0]  win_idx;
    logic [IW-1:0]  scan_idx;
    logic           grant_ok;
    logic [DW-1:0]  win_data1;
    logic [DW-1:0]  win_data2;

    // Scan starts one past the last winner so the previous winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_found && req_valid_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        win_data1 = '0;
        win_data2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_data1 = req_data1_i[i*DW +: DW];
                win_data2 = req_data2_i[i*DW +: DW];
            end
        end
    end

    assign grant_ok = (state_q == S_ARB) && !hold_i && !rst_i && win_found;

    always_comb begin
        req_ready_o = '0;
        if (grant_ok) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_ARB;
            gap_cnt_q  <= '0;
            rr_ptr_q   <= IW'(NUM_REQ - 1);
            data1_q    <= '0;
            data2_q    <= '0;
            data_en_q  <= 1'b0;
            grant_id_q <= '0;
        end else begin
            data_en_q <= 1'b0;
            case (state_q)
                S_ARB: begin
                    if (grant_ok) begin
                        data_en_q  <= 1'b1;
                        data1_q    <= win_data1;
                        data2_q    <= win_data2;
                        grant_id_q <= win_idx;
                        rr_ptr_q   <= win_idx;
                        if (GAP > 0) begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= GAP_INIT;
                        end
                    end
                end
                S_GAP: begin
                    // Pacing runs regardless of hold so the gap never stretches.
                    if (gap_cnt_q == '0) begin
                        state_q <= S_ARB;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_ARB;
            endcase
        end
    end

    assign data1_o    = data1_q;
    assign data2_o    = data2_q;
    assign data_en_o  = data_en_q;
    assign grant_id_o = grant_id_q;

`ifdef OP_IN_ARB_STAT_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    // Clear has priority over a same-cycle grant; counters stick at all-ones.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_i || stat_clr_i) begin
                cnt_q[i] <= '0;
            end else if (req_ready_o[i] && req_valid_i[i] && (cnt_q[i] != '1)) begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_op_in_arb.sv
// tb/tb_op_in_arb.sv - directed bench for op_in_arb (GAP 0/2/3 instances; stat checks with OP_IN_ARB_STAT_EN)
module tb_op_in_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data1;
    logic [15:0] req_data2;
    logic        hold;
    logic        stat_clr;

    logic [3:0]  ready0, ready2, ready3;
    logic [3:0]  d1_0, d2_0, d1_2, d2_2, d1_3, d2_3;
    logic        en0, en2, en3;
    logic [1:0]  gid0, gid2, gid3;
    logic [7:0]  stat0;
    logic [63:0] stat2, stat3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    op_in_arb #(.NUM_REQ(4), .DW(4), .GAP(0), .CNT_W(2)) u_gap0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid),
        .req_data1_i(req_data1), .req_data2_i(req_data2),
        .req_ready_o(ready0), .hold_i(hold),
`ifdef OP_IN_ARB_STAT_EN
        .stat_clr_i(stat_clr), .stat_cnt_o(stat0),
`endif
        .data1_o(d1_0), .data2_o(d2_0), .data_en_o(en0), .grant_id_o(gid0)
    );

    op_in_arb #(.NUM_REQ(4), .DW(4), .GAP(2)) u_gap2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid),
        .req_data1_i(req_data1), .req_data2_i(req_data2),
        .req_ready_o(ready2), .hold_i(hold),
`ifdef OP_IN_ARB_STAT_EN
        .stat_clr_i(stat_clr), .stat_cnt_o(stat2),
`endif
        .data1_o(d1_2), .data2_o(d2_2), .data_en_o(en2), .grant_id_o(gid2)
    );

    op_in_arb #(.NUM_REQ(4), .DW(4), .GAP(3)) u_gap3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid),
        .req_data1_i(req_data1), .req_data2_i(req_data2),
        .req_ready_o(ready3), .hold_i(hold),
`ifdef OP_IN_ARB_STAT_EN
        .stat_clr_i(stat_clr), .stat_cnt_o(stat3),
`endif
        .data1_o(d1_3), .data2_o(d2_3), .data_en_o(en3), .grant_id_o(gid3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        stat_clr  = 1'b0;
        req_valid = 4'b1111;
        req_data1 = {4'h3, 4'h2, 4'h1, 4'h0};
        req_data2 = {4'hC, 4'hD, 4'hE, 4'hF};

        // Reset held for 3 cycles with every requester valid
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rst_ready", 32'(ready0), 32'h0);
            tick();
            check("rst_en", 32'(en0), 32'h0);
            check("rst_d1", 32'(d1_0), 32'h0);
            check("rst_d2", 32'(d2_0), 32'h0);
            check("rst_gid", 32'(gid0), 32'h0);
        end
        rst = 1'b0;
        #1;

        // GAP=0 round robin, back-to-back issue
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr_ready%0d", k), 32'(ready0), 32'(4'b0001 << (k % 4)));
            tick();
            check($sformatf("rr_en%0d", k), 32'(en0), 32'h1);
            check($sformatf("rr_gid%0d", k), 32'(gid0), 32'(k % 4));
            check($sformatf("rr_d1_%0d", k), 32'(d1_0), 32'(k % 4));
            check($sformatf("rr_d2_%0d", k), 32'(d2_0), 32'((~(k % 4)) & 4'hF));
        end

        // GAP=2 with a single requester: one issue every third cycle
        req_valid = 4'b0100;
        req_data1 = {4'h3, 4'hA, 4'h1, 4'h0};
        req_data2 = {4'hC, 4'h5, 4'hE, 4'hF};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            check($sformatf("gap2_ready%0d", c), 32'(ready2), (c % 3 == 0) ? 32'h4 : 32'h0);
            tick();
            check($sformatf("gap2_en%0d", c), 32'(en2), (c % 3 == 0) ? 32'h1 : 32'h0);
            if (c % 3 == 0) begin
                check("gap2_gid", 32'(gid2), 32'h2);
                check("gap2_d1", 32'(d1_2), 32'hA);
                check("gap2_d2", 32'(d2_2), 32'h5);
            end
        end

        // hold blocks grants; release grants the same cycle
        req_valid = 4'b0010;
        hold      = 1'b1;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold_ready%0d", c), 32'(ready0), 32'h0);
            tick();
            check($sformatf("hold_en%0d", c), 32'(en0), 32'h0);
        end
        hold = 1'b0;
        #1;
        check("unhold_ready", 32'(ready0), 32'h2);
        tick();
        check("unhold_en", 32'(en0), 32'h1);
        check("unhold_gid", 32'(gid0), 32'h1);

        // Reset in S_GAP (GAP=3, gap_cnt=1) restores rr_ptr to NUM_REQ-1
        req_valid = 4'b0010;
        do_reset();
        check("gap3_first_ready", 32'(ready3), 32'h2);
        tick();
        check("gap3_first_en", 32'(en3), 32'h1);
        tick();
        check("gap3_in_gap", 32'(ready3), 32'h0);
        rst       = 1'b1;
        req_valid = 4'b1001;
        #1;
        check("gap3_rst_ready", 32'(ready3), 32'h0);
        tick();
        check("gap3_rst_en", 32'(en3), 32'h0);
        rst = 1'b0;
        #1;
        check("gap3_after_rst_ready", 32'(ready3), 32'h1);
        tick();
        check("gap3_after_rst_en", 32'(en3), 32'h1);
        check("gap3_after_rst_gid", 32'(gid3), 32'h0);

`ifdef OP_IN_ARB_STAT_EN
        // 2-bit counters saturate; clear beats a same-cycle grant
        req_valid = 4'b1000;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("stat_cnt3_%0d", c), 32'(stat0[7:6]), (c < 3) ? 32'(c + 1) : 32'h3);
        end
        check("stat_cnt0", 32'(stat0[1:0]), 32'h0);
        stat_clr = 1'b1;
        #1;
        check("stat_clr_grant", 32'(ready0), 32'h8);
        tick();
        check("stat_clr_cnt3", 32'(stat0[7:6]), 32'h0);
        stat_clr = 1'b0;
        tick();
        check("stat_after_clr", 32'(stat0[7:6]), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
